// File: rtl/keypad_debouncer_pkg.sv
// Shared types for the keypad debounce/history stage.
//   state_e  : debounce FSM states
//   cnt_op_e : debounce counter command
//   key_t    : 4-bit hex key code, KEY_RESET is its reset value
package keypad_debouncer_pkg;

  localparam int unsigned KEY_W = 4;

  typedef logic [KEY_W-1:0] key_t;

  localparam key_t KEY_RESET = 4'h0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_CLR  = 2'd1,
    CNT_ONE  = 2'd2,
    CNT_INC  = 2'd3
  } cnt_op_e;

endpackage

// File: rtl/keypad_debouncer_if.sv
// Scanner <-> debouncer <-> display bundle.
//   any_key/multi_key/key_code : raw per-cycle scanner observation
//   new_value/old_value        : two-digit key history for the display
//   key_strobe/key_held        : press pulse and keystroke-active level
interface keypad_debouncer_if;
  import keypad_debouncer_pkg::*;

  logic any_key;
  logic multi_key;
  key_t key_code;
  key_t new_value;
  key_t old_value;
  logic key_strobe;
  logic key_held;

  modport master (
    output any_key, multi_key, key_code,
    input  new_value, old_value, key_strobe, key_held
  );

  modport slave (
    input  any_key, multi_key, key_code,
    output new_value, old_value, key_strobe, key_held
  );

endinterface

// File: rtl/keypad_debouncer_counter.sv
// Debounce sample counter: clear / load-one / increment / hold.
//   clk, reset : slow clock, synchronous active-low reset
//   op         : counter command for this edge
//   tc_c       : count has reached DEBOUNCE_CYCLES-1 (combinational)
module keypad_debouncer_counter
  import keypad_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 48
) (
  input  logic    clk,
  input  logic    reset,
  input  cnt_op_e op,
  output logic    tc_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count; the FSM always leaves the counting state at terminal
  // count, so the increment never wraps.
  always_comb begin
    cnt_d = cnt_q;
    unique case (op)
      CNT_CLR:  cnt_d = '0;
      CNT_ONE:  cnt_d = CNT_W'(1);
      CNT_INC:  cnt_d = cnt_q + CNT_W'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_c = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/keypad_debouncer.sv
// Keypad debounce and two-digit history stage (slow-clock domain).
//   clk, reset : slow clock, synchronous active-low reset
//   kif        : scanner observation in, key history and strobes out
// A press is accepted after DEBOUNCE_CYCLES identical single-key samples;
// the release must also be stable for DEBOUNCE_CYCLES before re-arming.
module keypad_debouncer
  import keypad_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 48
) (
  input  logic               clk,
  input  logic               reset,
  keypad_debouncer_if.slave  kif
);

  state_e  state_q, state_d;
  key_t    cand_q, cand_d;
  key_t    new_q, new_d;
  key_t    old_q, old_d;
  logic    strobe_q, strobe_d;
  logic    held_q, held_d;
  cnt_op_e cnt_op;
  logic    tc_c;
  logic    valid_c;
  logic    match_c;

  keypad_debouncer_counter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .op   (cnt_op),
    .tc_c (tc_c)
  );

  // multi_key disqualifies an observation even if key_code looks valid
  assign valid_c = kif.any_key & ~kif.multi_key;
  assign match_c = valid_c & (kif.key_code == cand_q);

  // Next-state, history and counter command
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    new_d    = new_q;
    old_d    = old_q;
    strobe_d = 1'b0;
    cnt_op   = CNT_HOLD;
    unique case (state_q)
      IDLE: begin
        if (valid_c) begin
          cand_d  = kif.key_code;
          cnt_op  = CNT_ONE;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!match_c) begin
          cnt_op  = CNT_CLR;
          state_d = IDLE;
        end else if (tc_c) begin
          old_d    = new_q;
          new_d    = cand_q;
          strobe_d = 1'b1;
          cnt_op   = CNT_CLR;
          state_d  = HELD;
        end else begin
          cnt_op = CNT_INC;
        end
      end
      HELD: begin
        if (!kif.any_key) begin
          cnt_op  = CNT_ONE;
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (kif.any_key) begin
          // release bounce: back to the same keystroke, no new strobe
          cnt_op  = CNT_CLR;
          state_d = HELD;
        end else if (tc_c) begin
          cnt_op  = CNT_CLR;
          state_d = IDLE;
        end else begin
          cnt_op = CNT_INC;
        end
      end
      default: begin
        cnt_op  = CNT_CLR;
        state_d = IDLE;
      end
    endcase
    held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cand_q   <= KEY_RESET;
      new_q    <= KEY_RESET;
      old_q    <= KEY_RESET;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      new_q    <= new_d;
      old_q    <= old_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
    end
  end

  assign kif.new_value  = new_q;
  assign kif.old_value  = old_q;
  assign kif.key_strobe = strobe_q;
  assign kif.key_held   = held_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Bench for keypad_debouncer with DEBOUNCE_CYCLES=4. Expected {new,old}
// pairs are queued when a qualifying keystroke is driven and popped by a
// monitor each time key_strobe is seen.
module tb_keypad_debouncer;
  import keypad_debouncer_pkg::*;

  localparam int unsigned DC = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   strobe_cnt;
  logic [7:0] exp_q[$];

  keypad_debouncer_if kif ();

  keypad_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .kif  (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: each strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (kif.key_strobe === 1'b1) begin
      logic [7:0] e;
      strobe_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got new=%h old=%h, required no strobe",
                 kif.new_value, kif.old_value);
      end else begin
        e = exp_q.pop_front();
        if ({kif.new_value, kif.old_value} !== e) begin
          bad++;
          $display("FAIL strobe_history: got new=%h old=%h, required new=%h old=%h",
                   kif.new_value, kif.old_value, e[7:4], e[3:0]);
        end
      end
    end
  end

  // Drive one observation for n edges; returns just after a negedge.
  task automatic drive(input logic ak, input logic mk, input logic [3:0] code,
                       input int n);
    for (int i = 0; i < n; i++) begin
      kif.any_key   = ak;
      kif.multi_key = mk;
      kif.key_code  = code;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 2);
    total++; if (kif.new_value !== 4'h0) begin bad++; $display("FAIL reset_new: got %h, required 0", kif.new_value); end
    total++; if (kif.old_value !== 4'h0) begin bad++; $display("FAIL reset_old: got %h, required 0", kif.old_value); end
    total++; if (kif.key_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b, required 0", kif.key_strobe); end
    total++; if (kif.key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b, required 0", kif.key_held); end
    reset = 1'b1;
  endtask

  task automatic test_press();
    int s0 = strobe_cnt;
    exp_q.push_back({4'h5, 4'h0});
    drive(1'b1, 1'b0, 4'h5, DC - 1);
    total++; if (kif.new_value !== 4'h0) begin bad++; $display("FAIL press_early: got new=%h, required 0", kif.new_value); end
    drive(1'b1, 1'b0, 4'h5, 1);
    total++; if (kif.key_strobe !== 1'b1) begin bad++; $display("FAIL press_strobe_time: got %b, required 1", kif.key_strobe); end
    drive(1'b1, 1'b0, 4'h5, 6);
    total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL press_strobe_count: got %0d, required 1", strobe_cnt - s0); end
    total++; if (kif.key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b, required 1", kif.key_held); end
    total++; if ({kif.new_value, kif.old_value} !== 8'h50) begin bad++; $display("FAIL press_hist: got %h%h, required 50", kif.new_value, kif.old_value); end
  endtask

  task automatic test_back_to_back();
    int s0 = strobe_cnt;
    drive(1'b0, 1'b0, 4'h0, DC - 1);
    total++; if (kif.key_held !== 1'b1) begin bad++; $display("FAIL release_early_held: got %b, required 1", kif.key_held); end
    drive(1'b0, 1'b0, 4'h0, 1);
    total++; if (kif.key_held !== 1'b0) begin bad++; $display("FAIL release_held: got %b, required 0", kif.key_held); end
    exp_q.push_back({4'hA, 4'h5});
    drive(1'b1, 1'b0, 4'hA, 8);
    total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL b2b_strobe_count: got %0d, required 1", strobe_cnt - s0); end
    total++; if ({kif.new_value, kif.old_value} !== 8'hA5) begin bad++; $display("FAIL b2b_hist: got %h%h, required a5", kif.new_value, kif.old_value); end
    drive(1'b0, 1'b0, 4'h0, DC);
  endtask

  task automatic test_press_bounce();
    int s0 = strobe_cnt;
    drive(1'b1, 1'b0, 4'h3, 2);
    drive(1'b0, 1'b0, 4'h0, 1);
    drive(1'b1, 1'b0, 4'h3, 2);
    drive(1'b0, 1'b0, 4'h0, 4);
    total++; if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL bounce_strobe_count: got %0d, required 0", strobe_cnt - s0); end
    total++; if ({kif.new_value, kif.old_value} !== 8'hA5) begin bad++; $display("FAIL bounce_hist: got %h%h, required a5", kif.new_value, kif.old_value); end
    total++; if (kif.key_held !== 1'b0) begin bad++; $display("FAIL bounce_held: got %b, required 0", kif.key_held); end
  endtask

  task automatic test_multi_key();
    int s0 = strobe_cnt;
    exp_q.push_back({4'h7, 4'hA});
    drive(1'b1, 1'b0, 4'h7, DC);
    drive(1'b1, 1'b1, 4'h2, 5);
    drive(1'b0, 1'b0, 4'h0, DC);
    total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL multi_strobe_count: got %0d, required 1", strobe_cnt - s0); end
    total++; if ({kif.new_value, kif.old_value} !== 8'h7A) begin bad++; $display("FAIL multi_hist: got %h%h, required 7a", kif.new_value, kif.old_value); end
    total++; if (kif.key_held !== 1'b0) begin bad++; $display("FAIL multi_held: got %b, required 0", kif.key_held); end
  endtask

  task automatic test_release_bounce();
    int s0 = strobe_cnt;
    exp_q.push_back({4'h2, 4'h7});
    drive(1'b1, 1'b0, 4'h2, DC);
    drive(1'b0, 1'b0, 4'h0, 2);
    drive(1'b1, 1'b0, 4'h2, 1);
    drive(1'b0, 1'b0, 4'h0, DC - 1);
    total++; if (kif.key_held !== 1'b1) begin bad++; $display("FAIL relbounce_early_held: got %b, required 1", kif.key_held); end
    drive(1'b0, 1'b0, 4'h0, 1);
    total++; if (kif.key_held !== 1'b0) begin bad++; $display("FAIL relbounce_held: got %b, required 0", kif.key_held); end
    total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL relbounce_strobe_count: got %0d, required 1", strobe_cnt - s0); end
    total++; if ({kif.new_value, kif.old_value} !== 8'h27) begin bad++; $display("FAIL relbounce_hist: got %h%h, required 27", kif.new_value, kif.old_value); end
  endtask

  task automatic test_reset_mid();
    // Reset in the middle of PRESS_WAIT
    drive(1'b1, 1'b0, 4'h9, 2);
    reset = 1'b0;
    drive(1'b1, 1'b0, 4'h9, 1);
    reset = 1'b1;
    total++; if ({kif.new_value, kif.old_value, kif.key_strobe, kif.key_held} !== 10'h0) begin
      bad++; $display("FAIL rst_pw: got new=%h old=%h strobe=%b held=%b, required all 0",
                      kif.new_value, kif.old_value, kif.key_strobe, kif.key_held);
    end
    // Fresh registration after reset sees cleared history
    exp_q.push_back({4'h9, 4'h0});
    drive(1'b1, 1'b0, 4'h9, DC + 1);
    total++; if ({kif.new_value, kif.old_value} !== 8'h90) begin bad++; $display("FAIL rst_fresh_hist: got %h%h, required 90", kif.new_value, kif.old_value); end
    total++; if (kif.key_held !== 1'b1) begin bad++; $display("FAIL rst_fresh_held: got %b, required 1", kif.key_held); end
    // Reset in the middle of HELD
    reset = 1'b0;
    drive(1'b1, 1'b0, 4'h9, 1);
    reset = 1'b1;
    total++; if ({kif.new_value, kif.old_value, kif.key_strobe, kif.key_held} !== 10'h0) begin
      bad++; $display("FAIL rst_held: got new=%h old=%h strobe=%b held=%b, required all 0",
                      kif.new_value, kif.old_value, kif.key_strobe, kif.key_held);
    end
    drive(1'b0, 1'b0, 4'h0, DC + 1);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    strobe_cnt    = 0;
    reset         = 1'b0;
    kif.any_key   = 1'b0;
    kif.multi_key = 1'b0;
    kif.key_code  = 4'h0;
    test_reset();
    test_press();
    test_back_to_back();
    test_press_bounce();
    test_multi_key();
    test_release_bounce();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
